rv32imf_wfi_wake_ctrl: RTL and testbench
========================================

Name: rv32imf_wfi_wake_ctrl

Overview:
- Drives the sleep/wake interface on the sleep unit's input side.
- Sequences a WFI request through pipeline drain into sleep, and monitors enabled interrupts and debug requests.
- Produces the level `wake_from_sleep_o` and a wake-cause report.
- Runs on the ungated clock, so it stays live while the core clock is gated off.

Parameters:
- NUM_IRQ, 32, number of interrupt lines (legal range 1..32).
- WAKE_HOLD, 2, cycles `wake_from_sleep_o` is held in WAKE before returning to RUN (≥1).
- DRAIN_TIMEOUT, 64, maximum DRAIN cycles waiting for `core_busy_i` to fall (≥2).

Ports:
- clk_i  in  1  ungated core clock
- rst_n  in  1  asynchronous active-low reset
- wfi_req_i  in  1  controller WFI request, level, held until `wfi_ack_o` or withdrawn
- wfi_ack_o  out  1  one-cycle pulse: WFI completed (slept and woke, or skipped)
- core_busy_i  in  1  OR of IF/ctrl/LSU/APU busy
- irq_pending_i  in  NUM_IRQ  raw pending interrupt lines (mip)
- irq_enable_i  in  NUM_IRQ  per-line enable (mie)
- debug_req_i  in  1  debug halt request
- wake_from_sleep_o  out  1  level to sleep unit: 1 = keep core clock running
- sleeping_o  out  1  core is in SLEEP state
- wake_valid_o  out  1  one-cycle pulse: `wake_cause_o` valid
- wake_cause_o  out  6  0..NUM_IRQ-1 = IRQ index; 6'h3F = debug
- drain_timeout_o  out  1  one-cycle pulse: drain aborted on timeout

Behaviour:
- Reset is asynchronous, active-low on `rst_n`; clock is `clk_i`.
- Reset values:
  - state = RUN
  - `wake_from_sleep_o` = 1
  - `sleeping_o`, `wfi_ack_o`, `wake_valid_o`, `drain_timeout_o` = 0
  - `wake_cause_o` = 0
  - counters = 0
- Wake event is combinational: `ev = |(irq_pending_i & irq_enable_i) | debug_req_i`.
- All outputs come from flops only (Moore outputs, no glitches into the clock-gate enable).
- `wake_from_sleep_o` = 1 in RUN, DRAIN and WAKE; 0 only in SLEEP.
- `sleeping_o` = 1 only in SLEEP.
- RUN:
  - `wfi_req_i` & `ev` → stay RUN; `wfi_ack_o` pulses next cycle (WFI treated as NOP, no cause report).
  - `wfi_req_i` & !`ev` → DRAIN; drain counter cleared.
  - `wfi_req_i` is ignored in the cycle `wfi_ack_o` is high (prevents double-ack while the controller drops its request).
- DRAIN:
  - Counter increments each cycle.
  - Priority, highest first: !`wfi_req_i` → RUN, no ack (request withdrawn, e.g. flush); `ev` → RUN plus ack; counter == DRAIN_TIMEOUT-1 with `core_busy_i` → RUN plus ack plus `drain_timeout_o` pulse; !`core_busy_i` → SLEEP.
- SLEEP:
  - `ev` → WAKE.
  - Capture cause the same cycle:
    - debug takes priority → 6'h3F;
    - otherwise the lowest-index set bit of `irq_pending_i & irq_enable_i`.
  - `wfi_req_i` is don't-care in SLEEP.
- WAKE:
  - Hold counter counts WAKE_HOLD cycles, then → RUN.
  - On that transition `wfi_ack_o` and `wake_valid_o` pulse together (first RUN cycle), with `wake_cause_o` stable.
  - `wake_cause_o` holds its value until the next capture.
  - Events during WAKE are ignored (no re-capture).
- Latencies:
  - SLEEP with `ev` high in cycle N: `wake_from_sleep_o` = 1 at N+1.
  - Ack at N+1+WAKE_HOLD.
- Simultaneous events:
  - `ev` and !`core_busy_i` in the same DRAIN cycle: abort wins, never enter SLEEP.
  - `ev` falling in the same cycle as entry to SLEEP is not latched; the block sleeps until a new `ev`.
- Reset mid-operation from any state returns to RUN with reset values; no pulses are generated.
- Counters are sized `$clog2` of their parameter; counters and pulse flops saturate and never wrap.

Decomposition:
- Shared package: `wake_state_e` enum {RUN, DRAIN, SLEEP, WAKE}; constant `WAKE_CAUSE_DEBUG` = 6'h3F.
- Sub-module: `rv32imf_wake_prio_enc`, a parameterised lowest-index priority encoder (NUM_IRQ → 6-bit index plus valid).
- The FSM, counters and output flops stay in the top module.

Test Plan:
- Normal WFI with IRQ 5:
  - `wfi_req_i`=1 at cycle 0, `core_busy_i` falls at cycle 3 → SLEEP with `wake_from_sleep_o`=0.
  - `irq_pending_i[5]` & `irq_enable_i[5]` asserted → `wake_from_sleep_o`=1 next cycle.
  - Ack, `wake_valid_o` and `wake_cause_o`=5 after 2 more cycles.
- WFI with IRQ already pending (bit 3 enabled) → no DRAIN; `wfi_ack_o` next cycle; `wake_valid_o`=0; `wake_from_sleep_o` stays 1.
- Debug plus IRQ 0 and IRQ 7 together in SLEEP → `wake_cause_o`=6'h3F.
- IRQ 7 and IRQ 2 together in SLEEP, no debug → `wake_cause_o`=2.
- `core_busy_i` held high for 64 cycles in DRAIN → RUN, `drain_timeout_o` and `wfi_ack_o` pulse at cycle 64; `sleeping_o` never set.
- Withdraw/reset:
  - `wfi_req_i` dropped in DRAIN → RUN, no ack.
  - `rst_n` low in SLEEP → `wake_from_sleep_o`=1 and all pulses 0 immediately (asynchronous).
- Masked IRQ: `irq_pending_i`=32'hFFFF_FFFF with `irq_enable_i`=0 in SLEEP → stays asleep indefinitely.

Source files
------------

// File: rtl/rv32imf_wfi_wake_ctrl_pkg.sv
// Shared types and constants for the WFI sleep/wake controller.
// The state encoding is also exposed on the interface for observation.
package rv32imf_wfi_wake_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    SLEEP = 2'd2,
    WAKE  = 2'd3
  } wake_state_e;

  localparam int unsigned CAUSE_W = 6;
  localparam logic [CAUSE_W-1:0] WAKE_CAUSE_DEBUG = 6'h3F;

  // Counter width for a count limit, never narrower than one bit.
  function automatic int cnt_width(input int limit);
    return (limit > 1) ? $clog2(limit) : 1;
  endfunction

endpackage

// File: rtl/rv32imf_wfi_wake_ctrl_if.sv
// Sleep/wake handshake bundle between the controller side (master) and the wake controller (slave).
// Handshake: wfi_req_i is a level held until wfi_ack_o pulses or is withdrawn; every *_o is a registered one-cycle pulse or level.
interface rv32imf_wfi_wake_ctrl_if
  import rv32imf_wfi_wake_ctrl_pkg::*;
#(
  parameter int unsigned NUM_IRQ = 32
);
  logic               wfi_req_i;
  logic               wfi_ack_o;
  logic               core_busy_i;
  logic [NUM_IRQ-1:0] irq_pending_i;
  logic [NUM_IRQ-1:0] irq_enable_i;
  logic               debug_req_i;
  logic               wake_from_sleep_o;
  logic               sleeping_o;
  logic               wake_valid_o;
  logic [CAUSE_W-1:0] wake_cause_o;
  logic               drain_timeout_o;
  wake_state_e        state_o;

  modport master (
    output wfi_req_i, core_busy_i, irq_pending_i, irq_enable_i, debug_req_i,
    input  wfi_ack_o, wake_from_sleep_o, sleeping_o, wake_valid_o, wake_cause_o,
           drain_timeout_o, state_o
  );

  modport slave (
    input  wfi_req_i, core_busy_i, irq_pending_i, irq_enable_i, debug_req_i,
    output wfi_ack_o, wake_from_sleep_o, sleeping_o, wake_valid_o, wake_cause_o,
           drain_timeout_o, state_o
  );
endinterface

// File: rtl/rv32imf_wake_prio_enc.sv
// Lowest-index priority encoder: returns the index of the lowest set request bit and a valid flag.
module rv32imf_wake_prio_enc
  import rv32imf_wfi_wake_ctrl_pkg::*;
#(
  parameter int unsigned NUM_IRQ = 32
) (
  input  logic [NUM_IRQ-1:0] req_i,
  output logic [CAUSE_W-1:0] idx_o,
  output logic               valid_o
);

  // Scanning high-to-low lets the last hit (lowest index) win.
  always_comb begin
    idx_o   = '0;
    valid_o = 1'b0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        idx_o   = CAUSE_W'(i);
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rv32imf_wfi_wake_ctrl.sv
// WFI sequencer on the ungated clock: drains the pipeline, sleeps, and wakes on enabled IRQ or debug.
// All outputs are flops so the clock-gate enable never sees combinational glitches.
module rv32imf_wfi_wake_ctrl
  import rv32imf_wfi_wake_ctrl_pkg::*;
#(
  parameter int unsigned NUM_IRQ       = 32,
  parameter int unsigned WAKE_HOLD     = 2,
  parameter int unsigned DRAIN_TIMEOUT = 64
) (
  input  logic                    clk_i,
  input  logic                    rst_n,
  rv32imf_wfi_wake_ctrl_if.slave  bus
);

  localparam int unsigned DRAIN_W = cnt_width(DRAIN_TIMEOUT);
  localparam int unsigned HOLD_W  = cnt_width(WAKE_HOLD);
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_TIMEOUT - 1);
  localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(WAKE_HOLD - 1);

  wake_state_e        state_q, state_d;
  logic [DRAIN_W-1:0] drain_cnt_q, drain_cnt_d;
  logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
  logic               ack_q, ack_d;
  logic               valid_q, valid_d;
  logic               tmo_q, tmo_d;
  logic               wake_q, wake_d;
  logic               sleeping_q, sleeping_d;
  logic [CAUSE_W-1:0] cause_q, cause_d;

  logic [CAUSE_W-1:0] irq_idx;
  logic               irq_any;
  logic               ev;

  rv32imf_wake_prio_enc #(
    .NUM_IRQ (NUM_IRQ)
  ) u_prio_enc (
    .req_i   (bus.irq_pending_i & bus.irq_enable_i),
    .idx_o   (irq_idx),
    .valid_o (irq_any)
  );

  assign ev = irq_any | bus.debug_req_i;

  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    hold_cnt_d  = hold_cnt_q;
    cause_d     = cause_q;
    ack_d       = 1'b0;
    valid_d     = 1'b0;
    tmo_d       = 1'b0;

    unique case (state_q)
      RUN: begin
        // A request still high during the ack cycle is the old one being dropped.
        if (bus.wfi_req_i && !ack_q) begin
          if (ev) begin
            ack_d = 1'b1;
          end else begin
            state_d     = DRAIN;
            drain_cnt_d = '0;
          end
        end
      end
      DRAIN: begin
        drain_cnt_d = (drain_cnt_q == DRAIN_LAST) ? drain_cnt_q : drain_cnt_q + DRAIN_W'(1);
        if (!bus.wfi_req_i) begin
          state_d = RUN;
        end else if (ev) begin
          state_d = RUN;
          ack_d   = 1'b1;
        end else if ((drain_cnt_q == DRAIN_LAST) && bus.core_busy_i) begin
          state_d = RUN;
          ack_d   = 1'b1;
          tmo_d   = 1'b1;
        end else if (!bus.core_busy_i) begin
          state_d = SLEEP;
        end
      end
      SLEEP: begin
        if (ev) begin
          state_d    = WAKE;
          hold_cnt_d = '0;
          cause_d    = bus.debug_req_i ? WAKE_CAUSE_DEBUG : irq_idx;
        end
      end
      WAKE: begin
        if (hold_cnt_q == HOLD_LAST) begin
          state_d = RUN;
          ack_d   = 1'b1;
          valid_d = 1'b1;
        end else begin
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
      end
      default: state_d = RUN;
    endcase

    wake_d     = (state_d != SLEEP);
    sleeping_d = (state_d == SLEEP);
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      drain_cnt_q <= '0;
      hold_cnt_q  <= '0;
      cause_q     <= '0;
      ack_q       <= 1'b0;
      valid_q     <= 1'b0;
      tmo_q       <= 1'b0;
      wake_q      <= 1'b1;
      sleeping_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
      cause_q     <= cause_d;
      ack_q       <= ack_d;
      valid_q     <= valid_d;
      tmo_q       <= tmo_d;
      wake_q      <= wake_d;
      sleeping_q  <= sleeping_d;
    end
  end

  assign bus.wfi_ack_o         = ack_q;
  assign bus.wake_valid_o      = valid_q;
  assign bus.drain_timeout_o   = tmo_q;
  assign bus.wake_from_sleep_o = wake_q;
  assign bus.sleeping_o        = sleeping_q;
  assign bus.wake_cause_o      = cause_q;
  assign bus.state_o           = state_q;

endmodule

// File: tb/tb_rv32imf_wfi_wake_ctrl.sv
// Directed bench for the WFI wake controller: inputs change on the falling edge, outputs are checked there too.
module tb_rv32imf_wfi_wake_ctrl;
  import rv32imf_wfi_wake_ctrl_pkg::*;

  localparam int unsigned NUM_IRQ = 32;

  logic clk_i;
  logic rst_n;
  int   n_checks;
  int   n_errors;
  logic [CAUSE_W-1:0] exp_q[$];

  rv32imf_wfi_wake_ctrl_if #(.NUM_IRQ(NUM_IRQ)) bus ();

  rv32imf_wfi_wake_ctrl #(
    .NUM_IRQ       (NUM_IRQ),
    .WAKE_HOLD     (2),
    .DRAIN_TIMEOUT (64)
  ) dut (
    .clk_i (clk_i),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // clock / reset
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  task automatic idle_inputs();
    bus.wfi_req_i     = 1'b0;
    bus.core_busy_i   = 1'b0;
    bus.irq_pending_i = '0;
    bus.irq_enable_i  = '0;
    bus.debug_req_i   = 1'b0;
  endtask

  task automatic enter_sleep(input string tag);
    bus.wfi_req_i   = 1'b1;
    bus.core_busy_i = 1'b1;
    tick(1);
    check({tag, "_drain"}, 32'(bus.state_o), 32'(DRAIN));
    bus.core_busy_i = 1'b0;
    tick(1);
    check({tag, "_sleeping"}, 32'(bus.sleeping_o), 32'd1);
    check({tag, "_wake_lo"}, 32'(bus.wake_from_sleep_o), 32'd0);
  endtask

  // Caller has raised the event; expect WAKE next cycle and ack+cause two cycles later.
  task automatic expect_wake(input string tag);
    logic [CAUSE_W-1:0] exp_cause;
    tick(1);
    check({tag, "_wake_hi"}, 32'(bus.wake_from_sleep_o), 32'd1);
    check({tag, "_in_wake"}, 32'(bus.state_o), 32'(WAKE));
    tick(1);
    check({tag, "_no_early_ack"}, 32'(bus.wfi_ack_o), 32'd0);
    idle_inputs();
    bus.wfi_req_i = 1'b1;
    tick(1);
    exp_cause = exp_q.pop_front();
    check({tag, "_ack"}, 32'(bus.wfi_ack_o), 32'd1);
    check({tag, "_valid"}, 32'(bus.wake_valid_o), 32'd1);
    check({tag, "_cause"}, 32'(bus.wake_cause_o), 32'(exp_cause));
    bus.wfi_req_i = 1'b0;
    tick(1);
    check({tag, "_ack_pulse"}, 32'(bus.wfi_ack_o | bus.wake_valid_o), 32'd0);
    check({tag, "_cause_hold"}, 32'(bus.wake_cause_o), 32'(exp_cause));
  endtask

  initial begin
    int saw_sleep;
    n_checks = 0;
    n_errors = 0;
    idle_inputs();
    rst_n = 1'b1;
    #3 rst_n = 1'b0;
    tick(2);
    check("rst_state", 32'(bus.state_o), 32'(RUN));
    check("rst_wake", 32'(bus.wake_from_sleep_o), 32'd1);
    check("rst_pulses", {29'd0, bus.wfi_ack_o, bus.wake_valid_o, bus.drain_timeout_o}, 32'd0);
    check("rst_sleep_cause", {25'd0, bus.sleeping_o, bus.wake_cause_o}, 32'd0);
    rst_n = 1'b1;
    tick(1);

    // Normal WFI, busy for three cycles, wake on IRQ 5.
    bus.wfi_req_i   = 1'b1;
    bus.core_busy_i = 1'b1;
    tick(3);
    check("n_drain", 32'(bus.state_o), 32'(DRAIN));
    bus.core_busy_i = 1'b0;
    tick(1);
    check("n_sleep", 32'(bus.sleeping_o), 32'd1);
    check("n_wake_lo", 32'(bus.wake_from_sleep_o), 32'd0);
    tick(3);
    check("n_still_sleep", 32'(bus.state_o), 32'(SLEEP));
    bus.irq_pending_i[5] = 1'b1;
    bus.irq_enable_i[5]  = 1'b1;
    exp_q.push_back(6'd5);
    expect_wake("irq5");

    // IRQ already pending: immediate ack, request held through the ack is not re-acked.
    bus.irq_pending_i[3] = 1'b1;
    bus.irq_enable_i[3]  = 1'b1;
    bus.wfi_req_i        = 1'b1;
    tick(1);
    check("nop_ack", 32'(bus.wfi_ack_o), 32'd1);
    check("nop_valid", 32'(bus.wake_valid_o), 32'd0);
    check("nop_state", 32'(bus.state_o), 32'(RUN));
    check("nop_wake", 32'(bus.wake_from_sleep_o), 32'd1);
    tick(1);
    check("nop_no_double_ack", 32'(bus.wfi_ack_o), 32'd0);
    idle_inputs();
    tick(1);

    // Debug beats IRQ 0 and IRQ 7.
    enter_sleep("dbg");
    bus.irq_pending_i = 32'h0000_0081;
    bus.irq_enable_i  = 32'h0000_0081;
    bus.debug_req_i   = 1'b1;
    exp_q.push_back(WAKE_CAUSE_DEBUG);
    expect_wake("dbg");

    // Lowest index wins.
    enter_sleep("lo");
    bus.irq_pending_i = 32'h0000_0084;
    bus.irq_enable_i  = 32'h0000_0084;
    exp_q.push_back(6'd2);
    expect_wake("lo");

    // Drain timeout with busy held.
    saw_sleep       = 0;
    bus.wfi_req_i   = 1'b1;
    bus.core_busy_i = 1'b1;
    for (int i = 0; i < 64; i++) begin
      tick(1);
      if (bus.sleeping_o) saw_sleep = 1;
    end
    check("tmo_before", 32'(bus.drain_timeout_o), 32'd0);
    check("tmo_still_drain", 32'(bus.state_o), 32'(DRAIN));
    tick(1);
    check("tmo_pulse", 32'(bus.drain_timeout_o), 32'd1);
    check("tmo_ack", 32'(bus.wfi_ack_o), 32'd1);
    check("tmo_state", 32'(bus.state_o), 32'(RUN));
    check("tmo_never_slept", 32'(saw_sleep), 32'd0);
    idle_inputs();
    tick(1);
    check("tmo_one_cycle", 32'(bus.drain_timeout_o), 32'd0);

    // Withdraw in DRAIN: back to RUN, no ack.
    bus.wfi_req_i   = 1'b1;
    bus.core_busy_i = 1'b1;
    tick(1);
    bus.wfi_req_i = 1'b0;
    tick(1);
    check("wd_state", 32'(bus.state_o), 32'(RUN));
    check("wd_no_ack", 32'(bus.wfi_ack_o), 32'd0);
    idle_inputs();
    tick(1);

    // Event and busy fall together in DRAIN: abort with ack, never sleep.
    bus.wfi_req_i   = 1'b1;
    bus.core_busy_i = 1'b1;
    tick(1);
    bus.core_busy_i      = 1'b0;
    bus.irq_pending_i[9] = 1'b1;
    bus.irq_enable_i[9]  = 1'b1;
    tick(1);
    check("abort_state", 32'(bus.state_o), 32'(RUN));
    check("abort_ack", 32'(bus.wfi_ack_o), 32'd1);
    check("abort_no_sleep", 32'(bus.sleeping_o), 32'd0);
    idle_inputs();
    tick(1);

    // Masked IRQs keep it asleep; enabling line 31 wakes it.
    enter_sleep("mask");
    bus.irq_pending_i = 32'hFFFF_FFFF;
    bus.irq_enable_i  = '0;
    tick(20);
    check("mask_asleep", 32'(bus.sleeping_o), 32'd1);
    check("mask_wake_lo", 32'(bus.wake_from_sleep_o), 32'd0);
    bus.irq_enable_i[31] = 1'b1;
    exp_q.push_back(6'd31);
    expect_wake("irq31");

    // Asynchronous reset while asleep.
    enter_sleep("rst");
    rst_n = 1'b0;
    #1;
    check("arst_wake", 32'(bus.wake_from_sleep_o), 32'd1);
    check("arst_state", 32'(bus.state_o), 32'(RUN));
    check("arst_pulses", {28'd0, bus.sleeping_o, bus.wfi_ack_o, bus.wake_valid_o, bus.drain_timeout_o}, 32'd0);
    check("arst_cause", 32'(bus.wake_cause_o), 32'd0);
    idle_inputs();
    tick(1);
    rst_n = 1'b1;
    tick(2);
    check("post_rst_state", 32'(bus.state_o), 32'(RUN));

    // final report
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
